// File: rtl/key_uart_sender.sv
// key_uart_sender: merges filtered PS2 make codes and button-latched switch bytes
// into a DEPTH-entry FIFO, drains it through an 8N1 UART transmitter, and keeps a
// shift history of transmitted bytes for the seven-segment scanner.
// Ports: clk/reset (sync, active-high); sw + btn_pulse and keycode + kflag are the
// two push sources; tx is the serial line (idle high); full/empty/count report FIFO
// occupancy; drop_cnt counts refused pushes (saturating); history holds sent bytes,
// [7:0] most recent.
module key_uart_sender #(
  parameter int DEPTH      = 16,
  parameter int DISP_BYTES = 2,
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              sw,
  input  logic                    btn_pulse,
  input  logic [15:0]             keycode,
  input  logic                    kflag,
  output logic                    tx,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              drop_cnt,
  output logic [8*DISP_BYTES-1:0] history
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int HW  = 8 * DISP_BYTES;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          kreq;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic [7:0]    push_dat;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;

  // Break codes (F0 xx) and the F0/E0 prefix bytes themselves are not keys.
  assign kreq = kflag && (keycode[15:8] != 8'hF0) &&
                (keycode[7:0] != 8'hF0) && (keycode[7:0] != 8'hE0);

  // Key byte wins a same-cycle collision; the switch byte is then lost.
  assign push_req = kreq | btn_pulse;
  assign push_dat = kreq ? keycode[7:0] : sw;

  assign pop     = (state == IDLE) && (count != '0);
  assign push_ok = push_req && ((count < DEPTH_C) || pop);

  // Up to two drops per cycle: a collision loser plus a refused push.
  assign drop_inc = {1'b0, push_req & ~push_ok} + {1'b0, kreq & btn_pulse};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // tx is registered and updated together with each state change, so the line
  // level always matches the state the FSM is in during that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      history  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_q <= mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            // Oldest byte falls off the top; newest lands in [7:0].
            history  <= HW'({history, shift_q});
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_uart_sender.sv
module tb_key_uart_sender;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic        btn_pulse;
  logic [15:0] keycode;
  logic        kflag;
  logic        tx;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic [15:0] history;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  key_uart_sender #(
    .DEPTH(4), .DISP_BYTES(2), .CLK_HZ(16), .BAUD(1)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_pulse(btn_pulse),
    .keycode(keycode), .kflag(kflag), .tx(tx), .full(full), .empty(empty),
    .count(count), .drop_cnt(drop_cnt), .history(history)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    sw        = v;
    btn_pulse = 1'b1;
    tick();
    btn_pulse = 1'b0;
  endtask

  task automatic key(input logic [15:0] k);
    keycode = k;
    kflag   = 1'b1;
    tick();
    kflag   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (DIV + 2) tick();
  endtask

  task automatic idle_line(input string name, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    chk(name, bad, 0);
  endtask

  // Monitor: decode each frame at mid-bit, compare against the scoreboard.
  logic [7:0] mon_byte;
  logic       mon_start;
  logic       mon_stop;
  bit         mon_abort;
  logic [7:0] mon_exp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_byte  = 8'h00;
        mon_start = 1'bx;
        mon_stop  = 1'bx;
        for (int c = 1; c <= 9*DIV + DIV/2; c++) begin
          @(negedge clk);
          if (reset !== 1'b0) begin
            mon_abort = 1'b1;
            break;
          end
          if (c == DIV/2) mon_start = tx;
          else if (c == 9*DIV + DIV/2) mon_stop = tx;
          else if (c > DIV/2 && ((c - DIV/2) % DIV) == 0)
            mon_byte[(c - DIV/2)/DIV - 1] = tx;
        end
        if (!mon_abort) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: got %0h expected none", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_start !== 1'b0 || mon_stop !== 1'b1 || mon_byte !== mon_exp) begin
              failures++;
              $display("FAIL tx_frame: got byte %0h start %b stop %b expected byte %0h start 0 stop 1",
                       mon_byte, mon_start, mon_stop, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    logic [9:0] frame;
    int bad;

    reset = 1'b1; sw = 8'h00; btn_pulse = 1'b0; keycode = 16'h0000; kflag = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_history", history, 0);

    idle_line("idle_tx_high", 50);
    chk("idle_empty", empty, 1);
    chk("idle_drop", drop_cnt, 0);

    // A5 through the switch path, with exact per-cycle waveform
    exp_q.push_back(8'hA5);
    pulse(8'hA5);
    chk("lat_count_after_push", count, 1);
    chk("lat_empty_after_push", empty, 0);
    chk("lat_tx_still_idle", tx, 1);
    tick();
    chk("lat_start_bit", tx, 0);
    chk("lat_count_after_pop", count, 0);
    frame = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int i = 1; i < 10*DIV; i++) begin
      tick();
      if (tx !== frame[i/DIV]) bad++;
    end
    chk("a5_waveform_bad_cycles", bad, 0);
    tick();
    chk("a5_history", history, 16'h00A5);
    chk("a5_tx_idle", tx, 1);
    repeat (DIV) tick();

    // Key path and filter
    exp_q.push_back(8'h1C);
    key(16'h001C);
    chk("key_1c_count", count, 1);
    wait_drain(500);
    chk("key_1c_history", history, 16'hA51C);
    key(16'hF01C);
    chk("break_not_queued", count, 0);
    key(16'h00F0);
    chk("f0_not_queued", count, 0);
    key(16'h00E0);
    chk("e0_not_queued", count, 0);
    chk("filter_no_drop", drop_cnt, 0);
    idle_line("filter_no_frame", 2*DIV);

    // Overflow during a frame
    exp_q.push_back(8'h11);
    pulse(8'h11);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_q.push_back(8'h21 + 8'(k));
      pulse(8'h21 + 8'(k));
      if (k == 3) begin
        chk("ovf_full", full, 1);
        chk("ovf_count4", count, 4);
      end
      tick();
    end
    chk("ovf_count", count, 4);
    chk("ovf_drop", drop_cnt, 2);
    wait_drain(2000);
    chk("ovf_history", history, 16'h2324);
    chk("ovf_empty", empty, 1);

    // Same-cycle key and button: key wins, switch byte dropped
    exp_q.push_back(8'h29);
    keycode = 16'h0029; sw = 8'h77; kflag = 1'b1; btn_pulse = 1'b1;
    tick();
    kflag = 1'b0; btn_pulse = 1'b0;
    chk("collide_drop", drop_cnt, 3);
    chk("collide_count", count, 1);
    wait_drain(500);
    chk("collide_history", history, 16'h2429);

    // Mid-frame reset with bytes queued
    exp_q.push_back(8'h31);
    pulse(8'h31);
    pulse(8'h32);
    pulse(8'h33);
    repeat (30) tick();
    chk("pre_reset_count", count, 2);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_history", history, 0);
    idle_line("midrst_silent", 25*DIV);
    chk("midrst_count_end", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
